bipolar_bit_serializer: RTL and testbench
=========================================

BIPOLAR_BIT_SERIALIZER -- requirements
Module: bipolar_bit_serializer

Interface
REQ-001 Parameter inBits: default 4; bit width of each bipolar magnitude lane.
REQ-002 Parameter numLanes: default 1; number of parallel lanes.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 nrst  input  1  reset, asynchronous, active-low.
REQ-005 in_valid  input  1  a bipolar vector is offered.
REQ-006 in_ready  output  1  block can accept a vector this cycle.
REQ-007 unsigned_inputs  input  1  mode qualifier, sampled with the vector.
REQ-008 bipolar_p  input  [numLanes-1:0][inBits-1:0]  positive-polarity magnitudes.
REQ-009 bipolar_n  input  [numLanes-1:0][inBits-1:0]  negative-polarity magnitudes.
REQ-010 out_valid  output  1  wordline beat valid.
REQ-011 out_ready  input  1  downstream consumes beat.
REQ-012 wl_p  output  [numLanes-1:0]  current bit of each positive magnitude.
REQ-013 wl_n  output  [numLanes-1:0]  current bit of each negative magnitude.
REQ-014 bit_idx  output  $clog2(inBits)  binary weight of current beat (0 = LSB).
REQ-015 out_last  output  1  current beat is final beat of the vector.
REQ-016 ovf_err  output  1  sticky signed-magnitude overflow flag.

Function
REQ-017 The block SHALL implement two states: IDLE and SHIFT.
REQ-018 Input accept SHALL occur on a rising edge where in_valid && in_ready; bipolar_p, bipolar_n, unsigned_inputs are captured into registers.
REQ-019 in_ready SHALL be 1 in IDLE, and 1 in SHIFT only when out_valid && out_ready && out_last (back-to-back accept); otherwise 0.
REQ-020 Beat count N SHALL be inBits when captured unsigned_inputs=1, inBits-1 when 0.
REQ-021 On accept the block SHALL enter SHIFT with bit_idx=0; beat 0 SHALL be visible in the cycle after the accepting edge (latency 1 cycle); all outputs SHALL be registered.
REQ-022 In SHIFT, wl_p[i]/wl_n[i] SHALL equal bit bit_idx of captured bipolar_p[i]/bipolar_n[i]; out_valid SHALL be 1.
REQ-023 bit_idx SHALL increment only on edges with out_valid && out_ready; with out_ready=0 all outputs SHALL hold stable.
REQ-024 out_last SHALL be 1 exactly when bit_idx == N-1.
REQ-025 On a consumed last beat: if in_valid, capture new vector and present its beat 0 next cycle (no bubble); else return to IDLE with out_valid=0.
REQ-026 In IDLE, wl_p, wl_n, bit_idx, out_last SHALL be 0.
REQ-027 At accept in signed mode, if bit inBits-1 of any lane of bipolar_p or bipolar_n is 1, ovf_err SHALL set and remain 1 until reset; that bit is not streamed.
REQ-028 ovf_err SHALL never set in unsigned mode.
REQ-029 Input changes while not accepting SHALL have no effect on outputs.

Reset
REQ-030 nrst=0 SHALL immediately force IDLE, out_valid=0, wl_p=0, wl_n=0, bit_idx=0, out_last=0, ovf_err=0, captured data=0, regardless of clk.
REQ-031 in_ready SHALL read 1 during and after reset; reset mid-stream SHALL abandon the vector with no further beats.

Verification
REQ-032 Reset mid-stream: nrst low during beat 1 -> out_valid=0, wl_p=wl_n=0, in_ready=1 same cycle; no beat 2 after release.
REQ-033 Signed, numLanes=2, p={0,3}, n={5,0} (lane1,lane0), out_ready=1 -> 3 beats: wl_p[0]=1,1,0; wl_n[1]=1,0,1; bit_idx 0,1,2; out_last on beat 2 only.
REQ-034 Unsigned, p[0]=4'b1001 -> 4 beats wl_p[0]=1,0,0,1, out_last at bit_idx=3, ovf_err=0.
REQ-035 Backpressure: out_ready=0 for 2 cycles at bit_idx=1 -> wl_p, wl_n, bit_idx, out_last unchanged those cycles; bit_idx=2 follows first consumed edge.
REQ-036 Back-to-back: in_valid=1 during consumed last beat -> in_ready=1, next vector's bit_idx=0 beat in the following cycle, out_valid continuously 1.
REQ-037 Signed overflow: n[0]=4'b1000 -> ovf_err=1 from next cycle, beats wl_n[0]=0,0,0; ovf_err stays 1 over later vectors until nrst.

Source files
------------

// File: rtl/bipolar_bit_serializer.sv
// Bit-serial wordline driver. It captures one bipolar magnitude vector (one P and one N magnitude per lane)
// and streams it LSB-first, one bit-plane per beat, over a valid/ready handshake.
module bipolar_bit_serializer #(
  parameter int unsigned inBits   = 4,
  parameter int unsigned numLanes = 1
) (
  input  logic                               clk,
  input  logic                               nrst,
  input  logic                               in_valid,
  output logic                               in_ready,
  input  logic                               unsigned_inputs,
  input  logic [numLanes-1:0][inBits-1:0]    bipolar_p,
  input  logic [numLanes-1:0][inBits-1:0]    bipolar_n,
  output logic                               out_valid,
  input  logic                               out_ready,
  output logic [numLanes-1:0]                wl_p,
  output logic [numLanes-1:0]                wl_n,
  output logic [$clog2(inBits)-1:0]          bit_idx,
  output logic                               out_last,
  output logic                               ovf_err
);

  localparam int unsigned IW = $clog2(inBits);

  typedef enum logic {IDLE, SHIFT} state_e;

  state_e                            state_q, state_d;
  logic [numLanes-1:0][inBits-1:0]   p_q, p_d;
  logic [numLanes-1:0][inBits-1:0]   n_q, n_d;
  logic                              uns_q, uns_d;
  logic [IW-1:0]                     idx_q, idx_d;
  logic                              ovf_q, ovf_d;
  logic [numLanes-1:0]               wlp_q, wlp_d;
  logic [numLanes-1:0]               wln_q, wln_d;
  logic                              last_q, last_d;

  logic                              consume;
  logic                              accept;
  logic                              msb_any;
  logic [IW-1:0]                     last_idx_d;

  assign out_valid = (state_q == SHIFT);
  assign consume   = out_valid && out_ready;
  assign in_ready  = (state_q == IDLE) || (consume && last_q);
  assign accept    = in_valid && in_ready;

  assign wl_p     = wlp_q;
  assign wl_n     = wln_q;
  assign bit_idx  = idx_q;
  assign out_last = last_q;
  assign ovf_err  = ovf_q;

  always_comb begin
    msb_any = 1'b0;
    for (int unsigned i = 0; i < numLanes; i++) begin
      msb_any = msb_any | bipolar_p[i][inBits-1] | bipolar_n[i][inBits-1];
    end
  end

  // State and capture registers
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q <= IDLE;
      p_q     <= '0;
      n_q     <= '0;
      uns_q   <= 1'b0;
      idx_q   <= '0;
      ovf_q   <= 1'b0;
      wlp_q   <= '0;
      wln_q   <= '0;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      p_q     <= p_d;
      n_q     <= n_d;
      uns_q   <= uns_d;
      idx_q   <= idx_d;
      ovf_q   <= ovf_d;
      wlp_q   <= wlp_d;
      wln_q   <= wln_d;
      last_q  <= last_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    p_d     = p_q;
    n_d     = n_q;
    uns_d   = uns_q;
    idx_d   = idx_q;
    ovf_d   = ovf_q | (accept && !unsigned_inputs && msb_any);

    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = SHIFT;
          p_d     = bipolar_p;
          n_d     = bipolar_n;
          uns_d   = unsigned_inputs;
          idx_d   = '0;
        end
      end
      SHIFT: begin
        if (consume) begin
          if (last_q) begin
            if (in_valid) begin
              state_d = SHIFT;
              p_d     = bipolar_p;
              n_d     = bipolar_n;
              uns_d   = unsigned_inputs;
            end else begin
              state_d = IDLE;
            end
            idx_d = '0;
          end else begin
            idx_d = idx_q + IW'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs are precomputed from next state so that the beat registers line up with the state register
  always_comb begin
    wlp_d      = '0;
    wln_d      = '0;
    last_d     = 1'b0;
    last_idx_d = uns_d ? IW'(inBits - 1) : IW'(inBits - 2);
    if (state_d == SHIFT) begin
      for (int unsigned i = 0; i < numLanes; i++) begin
        wlp_d[i] = p_d[i][idx_d];
        wln_d[i] = n_d[i][idx_d];
      end
      last_d = (idx_d == last_idx_d);
    end
  end

endmodule

// File: tb/tb_bipolar_bit_serializer.sv
// Directed bench for bipolar_bit_serializer with two 4-bit lanes.
module tb_bipolar_bit_serializer;

  logic            clk = 1'b0;
  logic            nrst;
  logic            in_valid;
  logic            in_ready;
  logic            unsigned_inputs;
  logic [1:0][3:0] bp;
  logic [1:0][3:0] bn;
  logic            out_valid;
  logic            out_ready;
  logic [1:0]      wl_p;
  logic [1:0]      wl_n;
  logic [1:0]      bit_idx;
  logic            out_last;
  logic            ovf_err;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  bipolar_bit_serializer #(.inBits(4), .numLanes(2)) dut (
    .clk             (clk),
    .nrst            (nrst),
    .in_valid        (in_valid),
    .in_ready        (in_ready),
    .unsigned_inputs (unsigned_inputs),
    .bipolar_p       (bp),
    .bipolar_n       (bn),
    .out_valid       (out_valid),
    .out_ready       (out_ready),
    .wl_p            (wl_p),
    .wl_n            (wl_n),
    .bit_idx         (bit_idx),
    .out_last        (out_last),
    .ovf_err         (ovf_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input string tag, input logic [1:0] ep, input logic [1:0] en,
                      input logic [1:0] ei, input logic el);
    check({tag, ".valid"}, 32'(out_valid), 32'd1);
    check({tag, ".wl_p"}, 32'(wl_p), 32'(ep));
    check({tag, ".wl_n"}, 32'(wl_n), 32'(en));
    check({tag, ".idx"}, 32'(bit_idx), 32'(ei));
    check({tag, ".last"}, 32'(out_last), 32'(el));
  endtask

  task automatic idle_chk(input string tag);
    check({tag, ".valid"}, 32'(out_valid), 32'd0);
    check({tag, ".wl_p"}, 32'(wl_p), 32'd0);
    check({tag, ".wl_n"}, 32'(wl_n), 32'd0);
    check({tag, ".idx"}, 32'(bit_idx), 32'd0);
    check({tag, ".last"}, 32'(out_last), 32'd0);
    check({tag, ".in_ready"}, 32'(in_ready), 32'd1);
  endtask

  task automatic offer(input logic uns, input logic [3:0] p1, input logic [3:0] p0,
                       input logic [3:0] n1, input logic [3:0] n0);
    in_valid        = 1'b1;
    unsigned_inputs = uns;
    bp              = {p1, p0};
    bn              = {n1, n0};
  endtask

  initial begin
    nrst            = 1'b0;
    in_valid        = 1'b0;
    unsigned_inputs = 1'b0;
    bp              = '0;
    bn              = '0;
    out_ready       = 1'b1;

    #12;
    idle_chk("rst");
    check("rst.ovf", 32'(ovf_err), 32'd0);
    #2 nrst = 1'b1;
    tick();
    idle_chk("post_rst");

    // Signed, p={0,3}, n={5,0}
    offer(1'b0, 4'd0, 4'd3, 4'd5, 4'd0);
    check("sgn.in_ready", 32'(in_ready), 32'd1);
    tick();
    in_valid = 1'b0;
    beat("sgn.b0", 2'b01, 2'b10, 2'd0, 1'b0);
    tick();
    beat("sgn.b1", 2'b01, 2'b00, 2'd1, 1'b0);
    tick();
    beat("sgn.b2", 2'b00, 2'b10, 2'd2, 1'b1);
    tick();
    idle_chk("sgn.end");
    check("sgn.ovf", 32'(ovf_err), 32'd0);

    // Unsigned, p0=1001: MSB set but no overflow in unsigned mode
    offer(1'b1, 4'd0, 4'b1001, 4'd0, 4'd0);
    tick();
    in_valid = 1'b0;
    bp = '1;
    beat("uns.b0", 2'b01, 2'b00, 2'd0, 1'b0);
    tick();
    beat("uns.b1", 2'b00, 2'b00, 2'd1, 1'b0);
    tick();
    beat("uns.b2", 2'b00, 2'b00, 2'd2, 1'b0);
    tick();
    beat("uns.b3", 2'b01, 2'b00, 2'd3, 1'b1);
    check("uns.ovf", 32'(ovf_err), 32'd0);
    tick();
    idle_chk("uns.end");

    // Backpressure at bit_idx=1
    offer(1'b1, 4'd0, 4'd6, 4'd10, 4'd0);
    tick();
    in_valid = 1'b0;
    beat("bp.b0", 2'b00, 2'b00, 2'd0, 1'b0);
    tick();
    out_ready = 1'b0;
    beat("bp.b1", 2'b01, 2'b10, 2'd1, 1'b0);
    check("bp.in_ready", 32'(in_ready), 32'd0);
    tick();
    beat("bp.hold1", 2'b01, 2'b10, 2'd1, 1'b0);
    tick();
    beat("bp.hold2", 2'b01, 2'b10, 2'd1, 1'b0);
    out_ready = 1'b1;
    tick();
    beat("bp.b2", 2'b01, 2'b00, 2'd2, 1'b0);
    tick();
    beat("bp.b3", 2'b00, 2'b10, 2'd3, 1'b1);
    tick();
    idle_chk("bp.end");

    // Back-to-back: signed p0=5 then unsigned p0=1100
    offer(1'b0, 4'd0, 4'd5, 4'd0, 4'd0);
    tick();
    in_valid = 1'b0;
    beat("b2b.a0", 2'b01, 2'b00, 2'd0, 1'b0);
    tick();
    beat("b2b.a1", 2'b00, 2'b00, 2'd1, 1'b0);
    tick();
    offer(1'b1, 4'd0, 4'b1100, 4'd0, 4'd0);
    beat("b2b.a2", 2'b01, 2'b00, 2'd2, 1'b1);
    check("b2b.in_ready", 32'(in_ready), 32'd1);
    tick();
    in_valid = 1'b0;
    beat("b2b.b0", 2'b00, 2'b00, 2'd0, 1'b0);
    tick();
    beat("b2b.b1", 2'b00, 2'b00, 2'd1, 1'b0);
    tick();
    beat("b2b.b2", 2'b01, 2'b00, 2'd2, 1'b0);
    tick();
    beat("b2b.b3", 2'b01, 2'b00, 2'd3, 1'b1);
    tick();
    idle_chk("b2b.end");

    // Signed overflow: n0=1000, flag is sticky across a later clean vector
    offer(1'b0, 4'd0, 4'd0, 4'd0, 4'b1000);
    tick();
    in_valid = 1'b0;
    check("ovf.set", 32'(ovf_err), 32'd1);
    beat("ovf.b0", 2'b00, 2'b00, 2'd0, 1'b0);
    tick();
    beat("ovf.b1", 2'b00, 2'b00, 2'd1, 1'b0);
    tick();
    beat("ovf.b2", 2'b00, 2'b00, 2'd2, 1'b1);
    tick();
    idle_chk("ovf.end");
    offer(1'b0, 4'd0, 4'd1, 4'd0, 4'd0);
    tick();
    in_valid = 1'b0;
    beat("ovf2.b0", 2'b01, 2'b00, 2'd0, 1'b0);
    check("ovf.sticky", 32'(ovf_err), 32'd1);
    tick();
    tick();
    tick();
    idle_chk("ovf2.end");
    check("ovf.sticky_idle", 32'(ovf_err), 32'd1);

    // Reset during beat 1 abandons the vector
    offer(1'b1, 4'd0, 4'hF, 4'hF, 4'd0);
    tick();
    in_valid = 1'b0;
    beat("mrst.b0", 2'b01, 2'b10, 2'd0, 1'b0);
    tick();
    beat("mrst.b1", 2'b01, 2'b10, 2'd1, 1'b0);
    #2 nrst = 1'b0;
    #1;
    idle_chk("mrst.during");
    check("mrst.ovf", 32'(ovf_err), 32'd0);
    #2 nrst = 1'b1;
    tick();
    idle_chk("mrst.after1");
    tick();
    idle_chk("mrst.after2");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
